// File: rtl/poly_input_loader.sv
// poly_input_loader: streams one AMNS operand set (A, B, M, M_prime_0) from BRAM into the register bank; optional POLY_LOADER_SKIP_CONST_EN adds load_const_i to skip M/M_prime_0
module poly_input_loader #(
  parameter int WORD_WIDTH = 17,
  parameter int N = 5,
  parameter int S = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BRAM_LAT = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
`ifdef POLY_LOADER_SKIP_CONST_EN
  input  logic                  load_const_i,
`endif
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  bram_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  input  logic [WORD_WIDTH-1:0] bram_dout_i,
  output logic [1:0]            INPUT_reg_sel_o,
  output logic                  INPUT_reg_en_o,
  output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int NS = N * S;
  localparam int T_FULL = 3 * NS + N;
  localparam int CW = $clog2(T_FULL + 1);
  localparam int DW = $clog2(BRAM_LAT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt, t_last;
  logic [DW-1:0] dcnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0] tag;
  logic en_dl [BRAM_LAT];
  logic en_src [BRAM_LAT];
  logic [1:0] sel_dl [BRAM_LAT];
  logic [1:0] sel_src [BRAM_LAT];
`ifdef POLY_LOADER_SKIP_CONST_EN
  logic const_q;
  assign t_last = const_q ? CW'(T_FULL - 1) : CW'(2 * NS - 1);
  // remember whether this load includes the constant operands
  always_ff @(posedge clock_i)
    if (reset_i) const_q <= 1'b0;
    else if (state == IDLE && start_i) const_q <= load_const_i;
`else
  assign t_last = CW'(T_FULL - 1);
`endif
  assign bram_en_o = state == ISSUE;
  assign bram_addr_o = bram_en_o ? base_q + ADDR_WIDTH'(cnt) : '0;
  assign tag = cnt < CW'(NS) ? 2'd0 : cnt < CW'(2 * NS) ? 2'd1 : cnt < CW'(3 * NS) ? 2'd2 : 2'd3;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign INPUT_reg_din_o = bram_dout_i;
  assign INPUT_reg_en_o = en_dl[BRAM_LAT-1];
  assign INPUT_reg_sel_o = sel_dl[BRAM_LAT-1];
  // sequencer: issue T reads, wait out the BRAM latency, pulse done
  always_ff @(posedge clock_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      dcnt <= '0;
      base_q <= '0;
    end else
      case (state)
        IDLE: if (start_i) begin
          state <= ISSUE;
          base_q <= base_addr_i;
          cnt <= '0;
        end
        ISSUE: if (cnt == t_last) begin
          state <= DRAIN;
          dcnt <= DW'(BRAM_LAT - 1);
        end else cnt <= cnt + CW'(1);
        DRAIN: if (dcnt == '0) state <= DONE;
          else dcnt <= dcnt - DW'(1);
        default: state <= IDLE;
      endcase
  // feed of each delay stage: issue side for stage 0, previous stage otherwise
  always_comb begin
    en_src[0] = bram_en_o;
    sel_src[0] = tag;
    for (int i = 1; i < BRAM_LAT; i++) begin
      en_src[i] = en_dl[i-1];
      sel_src[i] = sel_dl[i-1];
    end
  end
  // align enable/select with returning BRAM data; select holds while idle
  always_ff @(posedge clock_i)
    if (reset_i)
      for (int i = 0; i < BRAM_LAT; i++) begin
        en_dl[i] <= 1'b0;
        sel_dl[i] <= 2'd0;
      end
    else
      for (int i = 0; i < BRAM_LAT; i++) begin
        en_dl[i] <= en_src[i];
        if (en_src[i]) sel_dl[i] <= sel_src[i];
      end
endmodule

// File: tb/tb_poly_input_loader.sv
// tb_poly_input_loader: model-checked directed bench for poly_input_loader
module tb_poly_input_loader;
  localparam int L = 2;
  localparam int NS = 20;
  localparam int TF = 65;
  logic clk = 1'b0;
  logic reset_i = 1'b1, start_i = 1'b0;
  logic load_const_i = 1'b1;
  logic [9:0] base_addr_i = '0;
  logic bram_en_o, INPUT_reg_en_o, busy_o, done_o;
  logic [9:0] bram_addr_o;
  logic [16:0] bram_dout_i, INPUT_reg_din_o;
  logic [1:0] INPUT_reg_sel_o;
  logic [16:0] pipe [L];
  int checks = 0, errors = 0;
  int cyc = 0;
  int act = 0, st = 0, dn = 0, mt = 0, mb = 0;
  int en_cnt, first_en, last_en, first_din, last_din, din16, done_cnt, busy_first, busy_last;
  int sel_cnt [4];
  int dq [$];

  poly_input_loader dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i),
`ifdef POLY_LOADER_SKIP_CONST_EN
    .load_const_i(load_const_i),
`endif
    .base_addr_i(base_addr_i), .bram_en_o(bram_en_o), .bram_addr_o(bram_addr_o),
    .bram_dout_i(bram_dout_i), .INPUT_reg_sel_o(INPUT_reg_sel_o), .INPUT_reg_en_o(INPUT_reg_en_o),
    .INPUT_reg_din_o(INPUT_reg_din_o), .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  // BRAM holding data = address, read latency L
  always @(posedge clk) begin
    pipe[0] <= bram_en_o ? 17'(bram_addr_o) : 17'd0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_dout_i = pipe[L-1];

  function automatic int words(input logic lc);
`ifdef POLY_LOADER_SKIP_CONST_EN
    return lc ? TF : 2 * NS;
`else
    return TF;
`endif
  endfunction

  function automatic int tag_of(input int j);
    return j < NS ? 0 : j < 2 * NS ? 1 : j < 3 * NS ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, a, e, cyc);
    end
  endtask

  // model: a load accepted at edge st with T words owns cycles st+1 .. st+T+L+1
  always @(posedge clk) begin
    if (reset_i) act <= 0;
    else if (start_i && (act == 0 || cyc > dn)) begin
      act <= 1;
      st <= cyc;
      mb <= int'(base_addr_i);
      mt <= words(load_const_i);
      dn <= cyc + words(load_const_i) + L + 1;
    end
    cyc <= cyc + 1;
  end

  // compare every cycle against the model, and gather stats for literal checks
  always @(negedge clk) begin
    int k;
    k = cyc - st - 1;
    chk("busy", int'(busy_o), int'(act != 0 && cyc >= st + 1 && cyc <= dn));
    chk("done", int'(done_o), int'(act != 0 && cyc == dn));
    chk("bram_en", int'(bram_en_o), int'(act != 0 && k >= 0 && k < mt));
    chk("reg_en", int'(INPUT_reg_en_o), int'(act != 0 && k >= L && k < mt + L));
    if (act != 0 && k >= 0 && k < mt) chk("addr", int'(bram_addr_o), (mb + k) % 1024);
    if (act != 0 && k >= L && k < mt + L) begin
      chk("din", int'(INPUT_reg_din_o), (mb + k - L) % 1024);
      chk("sel", int'(INPUT_reg_sel_o), tag_of(k - L));
    end
    if (INPUT_reg_en_o) begin
      if (en_cnt == 0) begin first_en = cyc; first_din = int'(INPUT_reg_din_o); end
      if (en_cnt == 16) din16 = int'(INPUT_reg_din_o);
      en_cnt++;
      last_en = cyc;
      last_din = int'(INPUT_reg_din_o);
      sel_cnt[INPUT_reg_sel_o]++;
    end
    if (busy_o) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (done_o) begin done_cnt++; dq.push_back(cyc); end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic clr;
    en_cnt = 0; first_en = -1; last_en = -1; first_din = -1; last_din = -1; din16 = -1;
    done_cnt = 0; busy_first = -1; busy_last = -1;
    for (int i = 0; i < 4; i++) sel_cnt[i] = 0;
    dq.delete();
  endtask

  task automatic wait_done(input int lim);
    int t0;
    t0 = cyc;
    while (done_cnt == 0 && cyc < t0 + lim) tick();
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_load(input logic [9:0] b, output int c);
    clr();
    base_addr_i = b;
    c = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(300);
    repeat (3) tick();
  endtask

  initial begin
    int c, c2;
    clr();
    repeat (3) tick();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_bram_en", int'(bram_en_o), 0);
    chk("rst_addr", int'(bram_addr_o), 0);
    chk("rst_reg_en", int'(INPUT_reg_en_o), 0);
    chk("rst_sel", int'(INPUT_reg_sel_o), 0);
    reset_i = 1'b0;
    repeat (2) tick();
    // full load from base 0
    run_load(10'h000, c);
    chk("t1_en_cnt", en_cnt, 65);
    chk("t1_first_en", first_en - c, 3);
    chk("t1_last_en", last_en - c, 67);
    chk("t1_done", dq[0] - c, 68);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_sel0", sel_cnt[0], 20);
    chk("t1_sel1", sel_cnt[1], 20);
    chk("t1_sel2", sel_cnt[2], 20);
    chk("t1_sel3", sel_cnt[3], 5);
    chk("t1_first_din", first_din, 0);
    chk("t1_last_din", last_din, 64);
    chk("t1_busy_first", busy_first - c, 1);
    chk("t1_busy_last", busy_last - c, 68);
    // address wrap
    run_load(10'h3F0, c);
    chk("t2_en_cnt", en_cnt, 65);
    chk("t2_first_din", first_din, 'h3F0);
    chk("t2_din16", din16, 0);
    chk("t2_last_din", last_din, 'h030);
    chk("t2_done", dq[0] - c, 68);
    // start while busy is ignored
    clr();
    base_addr_i = 10'h010;
    c = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    go_to(c + 10);
    start_i = 1'b1;
    go_to(c + 31);
    start_i = 1'b0;
    go_to(c + 100);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done", dq.size() > 0 ? dq[0] - c : -1, 68);
    chk("t3_en_cnt", en_cnt, 65);
    // reset mid-load, then a fresh load
    clr();
    base_addr_i = 10'h000;
    c = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    go_to(c + 30);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    go_to(c + 35);
    chk("t4_last_en", last_en - c, 30);
    chk("t4_busy_last", busy_last - c, 30);
    chk("t4_done_cnt", done_cnt, 0);
    clr();
    c2 = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(300);
    chk("t4_done2", done_cnt > 0 ? dq[0] - c : -1, 35 + 68);
    chk("t4_en_cnt2", en_cnt, 65);
    chk("t4_first_en2", first_en - c2, 3);
    repeat (3) tick();
    // start held high: back-to-back loads
    clr();
    c = cyc;
    start_i = 1'b1;
    while (dq.size() < 3 && cyc < c + 300) tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("t5_done_cnt", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("t5_done0", dq[0] - c, 68);
      chk("t5_done1", dq[1] - c, 137);
      chk("t5_done2", dq[2] - c, 206);
    end
    chk("t5_en_cnt", en_cnt, 195);
`ifdef POLY_LOADER_SKIP_CONST_EN
    load_const_i = 1'b0;
    run_load(10'h000, c);
    chk("t6_en_cnt", en_cnt, 40);
    chk("t6_first_en", first_en - c, 3);
    chk("t6_last_en", last_en - c, 42);
    chk("t6_done", dq[0] - c, 43);
    chk("t6_sel_const", sel_cnt[2] + sel_cnt[3], 0);
    chk("t6_last_din", last_din, 39);
    load_const_i = 1'b1;
    run_load(10'h000, c);
    chk("t7_en_cnt", en_cnt, 65);
    chk("t7_done", dq[0] - c, 68);
    chk("t7_sel3", sel_cnt[3], 5);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_input_loader.md
Name: poly_input_loader

Overview:
- Sequencer directly upstream of the polynomial register bank. Reads one AMNS operand set from a single-port BRAM and streams it word by word into the bank's serial input port.
- Operand order is A, B, M, M_prime_0. Drives the bank's register-select, shift-enable and data inputs.
- Raises a done pulse when the last word has been shifted in, so the top-level controller can start the multiplier array.

Parameters:
- WORD_WIDTH, 17, width of one BRAM word and of one register-bank shift.
- N, 5, number of coefficients per AMNS polynomial.
- S, 4, number of WORD_WIDTH blocks per coefficient.
- ADDR_WIDTH, 10, BRAM address width.
- BRAM_LAT, 2, BRAM read latency in cycles; legal range 1..4.

Ports:
- clock_i, input, 1, system clock, rising edge.
- reset_i, input, 1, synchronous active-high reset.
- start_i, input, 1, request to load one operand set; sampled only in IDLE.
- base_addr_i, input, ADDR_WIDTH, BRAM address of A word 0; sampled with start_i.
- bram_en_o, input/output: output, 1, BRAM read enable.
- bram_addr_o, output, ADDR_WIDTH, BRAM read address.
- bram_dout_i, input, WORD_WIDTH, BRAM read data, valid BRAM_LAT cycles after the enabled address.
- INPUT_reg_sel_o, output, 2, bank register select: 0=A, 1=B, 2=M, 3=M_prime_0.
- INPUT_reg_en_o, output, 1, bank shift-load enable.
- INPUT_reg_din_o, output, WORD_WIDTH, bank input data.
- busy_o, output, 1, high from the cycle after start is accepted until done_o.
- done_o, output, 1, one-cycle completion pulse.

Behaviour:
- Memory map, relative to the latched base B:
  - A at B .. B+NS-1
  - B at B+NS .. B+2NS-1
  - M at B+2NS .. B+3NS-1
  - M_prime_0 at B+3NS .. B+3NS+N-1
- Total words T = 3*N*S + N. Addresses increment by 1 and wrap modulo 2^ADDR_WIDTH.
- Within each operand, the lowest address is issued first, so word k ends at bit offset k*WORD_WIDTH in the bank.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: outputs quiet. start_i=1 latches base_addr_i, clears the word counter, next state ISSUE.
  - ISSUE: one read per cycle, bram_en_o=1, bram_addr_o=B+cnt. The select tag is 0 for cnt<NS, 1 for cnt<2NS, 2 for cnt<3NS, else 3. After the cycle with cnt=T-1, next state DRAIN.
  - DRAIN: bram_en_o=0 for BRAM_LAT cycles (down-counter), then next state DONE.
  - DONE: done_o=1 for one cycle, next state IDLE.
- Alignment: bram_en_o and the select tag feed a BRAM_LAT-deep delay line.
  - Delay-line outputs drive INPUT_reg_en_o and INPUT_reg_sel_o.
  - INPUT_reg_din_o = bram_dout_i, combinational pass-through.
  - Result: en, sel and data are coherent in the same cycle.
- Timing from start accepted at edge 0:
  - ISSUE occupies cycles 1..T.
  - INPUT_reg_en_o is high in cycles 1+BRAM_LAT .. T+BRAM_LAT.
  - done_o is high in cycle T+BRAM_LAT+1.
  - busy_o is high in cycles 1..T+BRAM_LAT+1.
- start_i while busy is ignored; no queuing.
- start_i held high is re-accepted in the cycle after DONE.
- Reset values: FSM=IDLE, delay line cleared. All outputs 0: bram_en_o, bram_addr_o, INPUT_reg_sel_o, INPUT_reg_en_o, busy_o, done_o.
- INPUT_reg_din_o follows bram_dout_i unconditionally and is don't-care when en=0.
- Reset mid-operation takes effect at the next edge. In-flight delay-line entries are discarded, so no enable pulse may appear after reset.
- INPUT_reg_sel_o holds its last value when en=0; the bank ignores it then.

Optional Feature:
- Macro: POLY_LOADER_SKIP_CONST_EN.
- When defined:
  - Adds input port load_const_i (1 bit), sampled with start_i.
  - If load_const_i=0, only A and B are loaded. T=2*N*S, the M/M_prime_0 region is not read, and done timing uses the reduced T.
  - If load_const_i=1, behaviour is identical to the full load.
- When undefined: no port; all four operands are always loaded.

Test Plan:
- Defaults, N=5, S=4, BRAM_LAT=2, BRAM preloaded with data = address, base=0x000, start pulse at edge 0:
  - 65 enables in cycles 3..67.
  - sel=0 for din 0..19, 1 for 20..39, 2 for 40..59, 3 for 60..64.
  - done_o only in cycle 68; busy_o high in cycles 1..68.
- base=0x3F0 with ADDR_WIDTH=10: addresses run 0x3F0..0x3FF, then 0x000..0x030; din sequence matches exactly.
- start_i asserted again in cycles 10..30 of an active load: no restart, same single done at 68.
- reset_i pulsed at cycle 30: from cycle 31 en=0, busy=0, bram_en=0 with no stray enable. A new start at cycle 35 completes normally with done at cycle 35+68.
- start_i held high continuously: back-to-back loads with done in cycles 68, 137, 206.
- With POLY_LOADER_SKIP_CONST_EN defined and load_const_i=0: 40 enables in cycles 3..42, sel only 0/1, done in cycle 43. With load_const_i=1, the full default-case timing applies.
